rs_ff_monitor: RTL

Clocked response checker for the RS flip-flop lab. It observes the Set/Reset stimulus driven into the RS flip-flop design and the design's Q/Q_bar outputs. It holds its own reference model of the flip-flop and checks the design against it. It counts mismatches and forbidden (S=R=1) input events, and reports a pass/fail status. It sits beside the design in the top-level, on the receiving end of the stimulus/response path, and watches both sides.

---
 rtl/rs_ff_monitor.sv | 74 +++++++
 1 files changed

// File: rtl/rs_ff_monitor.sv
// rs_ff_monitor: checks an RS flip-flop design's Q/Q_bar against a pipelined reference model
module rs_ff_monitor #(
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             S_mon,
    input  logic             R_mon,
    input  logic             Q,
    input  logic             Q_bar,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] forbid_count,
    output logic [1:0]       state,
    output logic             pass
);
    typedef enum logic [1:0] {SYNC = 2'd0, CHECK = 2'd1, FORBID = 2'd2, FAULT = 2'd3} state_e;
    state_e             state_q, state_d;
    logic [LATENCY-1:0] pq_q, pq_d, pv_q, pv_d;
    logic [CNT_W-1:0]   err_q, err_d, forb_q, forb_d;
    logic               pulse_q, pass_q, pass_d;
    logic               forb, mism, cmp_v, cmp_q, all_v, ref_q_d, ref_v_d;
    // Reference model, expected-value pipeline (index 0 newest), compare, counters and FSM next state
    always_comb begin
        forb    = S_mon & R_mon;
        ref_q_d = (S_mon ^ R_mon) ? S_mon : pq_q[0];
        ref_v_d = (S_mon ^ R_mon) | (~forb & pv_q[0]);
        pq_d    = (pq_q << 1) | LATENCY'(ref_q_d);
        pv_d    = (pv_q << 1) | LATENCY'(ref_v_d);
        cmp_v   = pv_q[LATENCY-1];
        cmp_q   = pq_q[LATENCY-1];
        all_v   = &pv_q;
        mism    = cmp_v & ((Q != cmp_q) | (Q_bar == cmp_q));
        err_d   = err_q + CNT_W'(mism & ~&err_q);
        forb_d  = forb_q + CNT_W'(forb & ~&forb_q);
        state_d = state_q;
        unique case (state_q)
            SYNC:    state_d = mism ? FAULT : (cmp_v & ~forb) ? CHECK : SYNC;
            CHECK:   state_d = mism ? FAULT : forb ? FORBID : CHECK;
            FORBID:  state_d = mism ? FAULT : (all_v & ~forb) ? CHECK : FORBID;
            FAULT:   state_d = (STOP_ON_ERR | mism) ? FAULT : forb ? FORBID : CHECK;
            default: state_d = SYNC;
        endcase
        pass_d = (state_d == CHECK) && (err_d == '0);
    end
    // Register everything; reset and clear both flush the pipeline and return to SYNC
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            pq_q    <= '0;
            pv_q    <= '0;
            err_q   <= '0;
            forb_q  <= '0;
            state_q <= SYNC;
            pulse_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            pq_q    <= pq_d;
            pv_q    <= pv_d;
            err_q   <= err_d;
            forb_q  <= forb_d;
            state_q <= state_d;
            pulse_q <= mism;
            pass_q  <= pass_d;
        end
    end
    assign err_pulse    = pulse_q;
    assign err_count    = err_q;
    assign forbid_count = forb_q;
    assign state        = state_q;
    assign pass         = pass_q;
endmodule
